elevator_display_driver: RTL and testbench

//  Output end of the two-floor elevator controller: consumes floor, state and led_drive from the

---
 rtl/elevator_display_driver.sv | 227 ++++++++++++++++++++++
 tb/tb_elevator_display_driver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_display_driver.sv
`default_nettype none
// ============================================================================
// Module  : elevator_display_driver
// Brief   : Drives the 8-digit multiplexed seven-segment display and the board
//           LEDs for the two-floor elevator: floor, direction, travel countdown.
// Rev     : 1.0  initial release
// ============================================================================

module elevator_display_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000,
  parameter int SEC_DIV    = 50000000,
  parameter int TRAVEL_SEC = 4
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic [1:0] floor,
  input  logic [1:0] state,
  input  logic [3:0] led_drive,
  output logic [7:0] seg,
  output logic [7:0] dig_sel,
  output logic [3:0] led,
  output logic [1:0] led_dir
);

  localparam int c_SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int c_SEC_W   = (SEC_DIV   > 1) ? $clog2(SEC_DIV)   : 1;

  localparam logic [c_SCAN_W-1:0]  c_SCAN_MAX  = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_MAX = c_BLINK_W'(BLINK_DIV - 1);
  localparam logic [c_SEC_W-1:0]   c_SEC_MAX   = c_SEC_W'(SEC_DIV - 1);
  localparam logic [3:0]           c_TRAVEL    = 4'(TRAVEL_SEC);

  localparam logic [7:0] c_SEG_DASH  = 8'h40;
  localparam logic [7:0] c_SEG_UP    = 8'h3E;
  localparam logic [7:0] c_SEG_DOWN  = 8'h5E;
  localparam logic [7:0] c_SEG_BLANK = 8'h00;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_MOVING = 1'b1
  } travel_state_t;

  travel_state_t         r_fsm;
  logic [1:0]            r_floor;
  logic [1:0]            r_state;
  logic [3:0]            r_drive;
  logic [3:0]            r_drive_lat;
  logic [3:0]            r_countdown;
  logic [c_SEC_W-1:0]    r_sec_cnt;
  logic [c_BLINK_W-1:0]  r_blink_cnt;
  logic                  r_phase;
  logic [3:0]            r_led;
  logic [c_SCAN_W-1:0]   r_scan_cnt;
  logic [2:0]            r_idx;
  logic [7:0]            r_seg;
  logic [7:0]            r_dig_sel;
  logic [1:0]            r_led_dir;

  logic                  w_sec_wrap;
  logic                  w_blink_wrap;
  logic [7:0]            w_seg_code;
  logic [1:0]            w_dir_code;

  function automatic logic [7:0] num_glyph(input logic [3:0] v);
    case (v)
      4'd0:    num_glyph = 8'h3F;
      4'd1:    num_glyph = 8'h06;
      4'd2:    num_glyph = 8'h5B;
      4'd3:    num_glyph = 8'h4F;
      4'd4:    num_glyph = 8'h66;
      4'd5:    num_glyph = 8'h6D;
      4'd6:    num_glyph = 8'h7D;
      4'd7:    num_glyph = 8'h07;
      4'd8:    num_glyph = 8'h7F;
      4'd9:    num_glyph = 8'h6F;
      default: num_glyph = c_SEG_BLANK;
    endcase
  endfunction

  // Inputs are sampled once; everything downstream works from these copies.
  always_ff @(posedge clk_50mhz) begin
    if (!rst) begin
      r_floor <= 2'd0;
      r_state <= 2'd0;
      r_drive <= 4'd0;
    end else begin
      r_floor <= floor;
      r_state <= state;
      r_drive <= led_drive;
    end
  end

  assign w_sec_wrap   = (r_sec_cnt == c_SEC_MAX);
  assign w_blink_wrap = (r_blink_cnt == c_BLINK_MAX);

  // Travel FSM: a new nonzero request pattern (re)starts the countdown and blink.
  always_ff @(posedge clk_50mhz) begin
    if (!rst) begin
      r_fsm       <= ST_IDLE;
      r_drive_lat <= 4'd0;
      r_countdown <= 4'd0;
      r_sec_cnt   <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_led       <= 4'd0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (r_drive != 4'd0) begin
            r_fsm       <= ST_MOVING;
            r_drive_lat <= r_drive;
            r_countdown <= c_TRAVEL;
            r_sec_cnt   <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_led       <= r_drive;
          end else begin
            r_countdown <= 4'd0;
            r_sec_cnt   <= '0;
            r_blink_cnt <= '0;
            r_led       <= 4'd0;
          end
        end
        ST_MOVING: begin
          if (r_drive == 4'd0) begin
            r_fsm       <= ST_IDLE;
            r_countdown <= 4'd0;
            r_sec_cnt   <= '0;
            r_blink_cnt <= '0;
            r_led       <= 4'd0;
          end else if (r_drive != r_drive_lat) begin
            r_drive_lat <= r_drive;
            r_countdown <= c_TRAVEL;
            r_sec_cnt   <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_led       <= r_drive;
          end else begin
            if (w_sec_wrap) begin
              r_sec_cnt <= '0;
              if (r_countdown != 4'd0) begin
                r_countdown <= r_countdown - 4'd1;
              end
            end else begin
              r_sec_cnt <= r_sec_cnt + c_SEC_W'(1);
            end
            if (w_blink_wrap) begin
              r_blink_cnt <= '0;
              r_phase     <= ~r_phase;
            end else begin
              r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
            end
            // LED follows the phase that takes effect on this same edge
            r_led <= r_drive & {4{w_blink_wrap ? ~r_phase : r_phase}};
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_seg_code = c_SEG_BLANK;
    case (r_idx)
      3'd0: begin
        case (r_floor)
          2'd1:    w_seg_code = num_glyph(4'd1);
          2'd2:    w_seg_code = num_glyph(4'd2);
          default: w_seg_code = c_SEG_DASH;
        endcase
      end
      3'd2: begin
        if (r_fsm == ST_MOVING) begin
          w_seg_code = num_glyph(r_countdown);
        end
      end
      3'd7: begin
        case (r_state)
          2'd2:    w_seg_code = c_SEG_UP;
          2'd1:    w_seg_code = c_SEG_DOWN;
          2'd0:    w_seg_code = c_SEG_DASH;
          default: w_seg_code = c_SEG_BLANK;
        endcase
      end
      default: w_seg_code = c_SEG_BLANK;
    endcase
  end

  always_comb begin
    case (r_state)
      2'd2:    w_dir_code = 2'b01;
      2'd1:    w_dir_code = 2'b10;
      default: w_dir_code = 2'b00;
    endcase
  end

  // Digit enable and segment pattern come from the same index on the same edge.
  always_ff @(posedge clk_50mhz) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_idx      <= 3'd0;
      r_seg      <= 8'h00;
      r_dig_sel  <= 8'hFF;
      r_led_dir  <= 2'b00;
    end else begin
      if (r_scan_cnt == c_SCAN_MAX) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
      end
      r_dig_sel <= ~(8'd1 << r_idx);
      r_seg     <= w_seg_code;
      r_led_dir <= w_dir_code;
    end
  end

  assign seg     = r_seg;
  assign dig_sel = r_dig_sel;
  assign led     = r_led;
  assign led_dir = r_led_dir;

endmodule

`default_nettype wire

// File: tb/tb_elevator_display_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_elevator_display_driver
// Brief   : Vector table, directed travel sequences and randomized traffic
//           checked against a cycle-level behavioural model of the display.
// Rev     : 1.0  initial release
// ============================================================================

module tb_elevator_display_driver;

  localparam int SCAN_DIV   = 4;
  localparam int BLINK_DIV  = 8;
  localparam int SEC_DIV    = 16;
  localparam int TRAVEL_SEC = 4;

  localparam logic [7:0] NUMS [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                       8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic       clk_50mhz = 1'b0;
  logic       rst;
  logic [1:0] floor;
  logic [1:0] state;
  logic [3:0] led_drive;
  logic [7:0] seg;
  logic [7:0] dig_sel;
  logic [3:0] led;
  logic [1:0] led_dir;

  elevator_display_driver #(
    .SCAN_DIV   (SCAN_DIV),
    .BLINK_DIV  (BLINK_DIV),
    .SEC_DIV    (SEC_DIV),
    .TRAVEL_SEC (TRAVEL_SEC)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .floor     (floor),
    .state     (state),
    .led_drive (led_drive),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .led       (led),
    .led_dir   (led_dir)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: scan position and travel progress are elapsed-cycle counts.
  bit         model_valid = 0;
  int         m_scyc;
  int         m_mcyc;
  bit         m_moving;
  logic [3:0] m_lat;
  logic [1:0] m_floor;
  logic [1:0] m_state;
  logic [3:0] m_drive;
  logic [7:0] e_seg;
  logic [7:0] e_dig;
  logic [3:0] e_led;
  logic [1:0] e_dir;
  int         t_idx;
  int         t_cd;

  always @(posedge clk_50mhz) begin
    if (!rst) begin
      m_scyc = 0; m_mcyc = 0; m_moving = 0; m_lat = 0;
      m_floor = 0; m_state = 0; m_drive = 0;
      e_seg = 8'h00; e_dig = 8'hFF; e_led = 4'h0; e_dir = 2'b00;
      model_valid = 1;
    end else if (model_valid) begin
      t_idx = (m_scyc / SCAN_DIV) % 8;
      t_cd  = TRAVEL_SEC - (m_mcyc / SEC_DIV);
      if (t_cd < 0) t_cd = 0;
      e_dig = ~(8'd1 << t_idx);
      case (t_idx)
        0:       e_seg = (m_floor == 1) ? 8'h06 : (m_floor == 2) ? 8'h5B : 8'h40;
        2:       e_seg = m_moving ? NUMS[t_cd] : 8'h00;
        7:       e_seg = (m_state == 2) ? 8'h3E : (m_state == 1) ? 8'h5E :
                         (m_state == 0) ? 8'h40 : 8'h00;
        default: e_seg = 8'h00;
      endcase
      e_dir = (m_state == 2) ? 2'b01 : (m_state == 1) ? 2'b10 : 2'b00;
      if (m_moving && m_drive == 0) begin
        m_moving = 0;
      end else if (m_drive != 0 && (!m_moving || m_drive != m_lat)) begin
        m_moving = 1; m_mcyc = 0; m_lat = m_drive;
      end else if (m_moving) begin
        m_mcyc++;
      end
      e_led = (m_moving && ((m_mcyc / BLINK_DIV) % 2 == 0)) ? m_drive : 4'h0;
      m_scyc++;
      m_floor = floor; m_state = state; m_drive = led_drive;
    end
  end

  always @(negedge clk_50mhz) begin
    if (model_valid) begin
      check("model_seg", seg, e_seg);
      check("model_dig_sel", dig_sel, e_dig);
      check("model_led", {4'h0, led}, {4'h0, e_led});
      check("model_led_dir", {6'h0, led_dir}, {6'h0, e_dir});
    end
  end

  task automatic wait_dig(input logic [7:0] want, input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_50mhz);
      if (dig_sel == want) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s: dig_sel stuck at %02h, required %02h within 64 clks", name, dig_sel, want);
    end
  endtask

  typedef struct {
    logic [1:0] fl;
    logic [1:0] st;
    logic [7:0] d0;
    logic [7:0] d7;
    logic [1:0] dir;
  } vec_t;

  vec_t vecs [5];
  bit   ok;

  initial begin
    vecs[0] = '{fl: 2'd1, st: 2'd0, d0: 8'h06, d7: 8'h40, dir: 2'b00};
    vecs[1] = '{fl: 2'd2, st: 2'd2, d0: 8'h5B, d7: 8'h3E, dir: 2'b01};
    vecs[2] = '{fl: 2'd2, st: 2'd1, d0: 8'h5B, d7: 8'h5E, dir: 2'b10};
    vecs[3] = '{fl: 2'd3, st: 2'd3, d0: 8'h40, d7: 8'h00, dir: 2'b00};
    vecs[4] = '{fl: 2'd0, st: 2'd0, d0: 8'h40, d7: 8'h40, dir: 2'b00};

    rst = 1'b0; floor = 2'd1; state = 2'd0; led_drive = 4'h0;
    repeat (3) @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    check("reset_seg", seg, 8'h00);
    check("reset_dig_sel", dig_sel, 8'hFF);
    check("reset_led", {4'h0, led}, 8'h00);
    check("reset_led_dir", {6'h0, led_dir}, 8'h00);
    rst = 1'b1;

    // Idle display content for each floor/state pattern
    for (int v = 0; v < 5; v++) begin
      floor = vecs[v].fl; state = vecs[v].st; led_drive = 4'h0;
      repeat (4) @(negedge clk_50mhz);
      wait_dig(8'hFE, "vec_digit0_sel", ok);
      if (ok) check("vec_digit0", seg, vecs[v].d0);
      wait_dig(8'hFB, "vec_digit2_sel", ok);
      if (ok) check("vec_digit2_idle", seg, 8'h00);
      wait_dig(8'h7F, "vec_digit7_sel", ok);
      if (ok) check("vec_digit7", seg, vecs[v].d7);
      check("vec_led_dir", {6'h0, led_dir}, {6'h0, vecs[v].dir});
      check("vec_led_idle", {4'h0, led}, 8'h00);
    end

    // Move upward: blink pattern, countdown saturates at zero, then stop
    floor = 2'd1; state = 2'd2; led_drive = 4'b1000;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_50mhz);
      if (led != 4'h0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL move_start: led stayed %h, required 8 within 8 clks", led);
    end
    for (int i = 0; i < 32; i++) begin
      check("blink_pattern", {4'h0, led}, ((i / 8) % 2 == 0) ? 8'h08 : 8'h00);
      @(negedge clk_50mhz);
    end
    repeat (40) @(negedge clk_50mhz);
    wait_dig(8'hFB, "countdown_sel", ok);
    if (ok) check("countdown_zero", seg, 8'h3F);
    wait_dig(8'h7F, "dir_glyph_sel", ok);
    if (ok) check("dir_glyph_up", seg, 8'h3E);
    check("led_dir_up", {6'h0, led_dir}, 8'h01);
    led_drive = 4'h0;
    repeat (2) @(negedge clk_50mhz);
    check("stop_led_off", {4'h0, led}, 8'h00);
    wait_dig(8'hFB, "stop_digit2_sel", ok);
    if (ok) check("stop_digit2_blank", seg, 8'h00);

    // Request pattern change mid-move restarts blink phase
    led_drive = 4'b0001;
    repeat (20) @(negedge clk_50mhz);
    led_drive = 4'b0100;
    repeat (2) @(negedge clk_50mhz);
    check("reload_led", {4'h0, led}, 8'h04);
    repeat (7) @(negedge clk_50mhz);
    check("reload_phase_hold", {4'h0, led}, 8'h04);
    @(negedge clk_50mhz);
    check("reload_phase_toggle", {4'h0, led}, 8'h00);

    // Reset pulse mid-move, then fresh entry
    led_drive = 4'b0010;
    repeat (10) @(negedge clk_50mhz);
    rst = 1'b0;
    @(negedge clk_50mhz);
    check("midrst_seg", seg, 8'h00);
    check("midrst_dig_sel", dig_sel, 8'hFF);
    check("midrst_led", {4'h0, led}, 8'h00);
    check("midrst_led_dir", {6'h0, led_dir}, 8'h00);
    rst = 1'b1;
    @(negedge clk_50mhz);
    check("rerun_led_wait", {4'h0, led}, 8'h00);
    @(negedge clk_50mhz);
    check("rerun_led_on", {4'h0, led}, 8'h02);
    wait_dig(8'hFB, "rerun_digit2_sel", ok);
    if (ok) check("rerun_countdown_full", seg, 8'h66);

    // Randomized traffic, model-checked every cycle
    for (int k = 0; k < 60; k++) begin
      floor = 2'($urandom_range(0, 3));
      state = 2'($urandom_range(0, 3));
      led_drive = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) rst = 1'b0;
      repeat ($urandom_range(1, 40)) @(negedge clk_50mhz);
      rst = 1'b1;
    end
    repeat (4) @(negedge clk_50mhz);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
